// File: rtl/lock_pkg.sv
// Shared state type, display constant and width helper for the code_lock design.
package lock_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_UNLOCKED,
        ST_PROGRAM,
        ST_LOCKOUT
    } state_e;

    localparam logic [31:0] LED_UNLOCKED = '1;

    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stable-level counter and one-cycle rising-edge press pulse.
module btn_debounce
    import lock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1 << 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q, level_q, press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            // Any return to the accepted level restarts the stability window.
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
                press_q <= sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/code_lock.sv
// Combination lock: digit entry, failed-attempt lockout, idle timeout and
// runtime reprogramming of the code, driven by two debounced buttons.
module code_lock
    import lock_pkg::*;
#(
    parameter int unsigned                  DIGITS          = 4,
    parameter int unsigned                  DIGIT_W         = 4,
    parameter logic [DIGITS*DIGIT_W-1:0]    CODE            = 16'h3141,
    parameter int unsigned                  MAX_TRIES       = 3,
    parameter int unsigned                  LOCKOUT_CYCLES  = 1 << 24,
    parameter int unsigned                  TIMEOUT_CYCLES  = 1 << 26,
    parameter int unsigned                  DEBOUNCE_CYCLES = 1 << 20
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             btn_next,
    input  logic                             btn_enter,
    output logic [DIGIT_W-1:0]               led,
    output logic                             unlocked,
    output logic                             lockout,
    output logic                             programming,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count
);

    localparam int unsigned CODE_W = DIGITS * DIGIT_W;
    localparam int unsigned IDX_W  = cnt_width(DIGITS);
    localparam int unsigned FAIL_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned IDLE_W = cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned LOCK_W = cnt_width(LOCKOUT_CYCLES);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_TRIES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);

    logic np, ep;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk(clk), .rst(rst), .btn_i(btn_next), .press_o(np)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .clk(clk), .rst(rst), .btn_i(btn_enter), .press_o(ep)
    );

    state_e              state_q, state_d;
    logic [DIGIT_W-1:0]  digit_q, digit_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                mismatch_q, mismatch_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic [CODE_W-1:0]   code_q, code_d, shadow_q, shadow_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [LOCK_W-1:0]   lock_q, lock_d;
    logic [DIGIT_W-1:0]  led_q, led_d;
    logic                unlocked_q, lockout_q, programming_q;
    logic                miss, idle_run, timeout;

    always_comb begin
        state_d    = state_q;
        digit_d    = digit_q;
        idx_d      = idx_q;
        mismatch_d = mismatch_q;
        fail_d     = fail_q;
        code_d     = code_q;
        shadow_d   = shadow_q;
        lock_d     = '0;
        idle_d     = '0;
        miss       = mismatch_q | (digit_q != code_q[int'(idx_q)*DIGIT_W +: DIGIT_W]);
        idle_run   = (state_q == ST_ENTRY && (idx_q != '0 || digit_q != '0)) ||
                     state_q == ST_UNLOCKED || state_q == ST_PROGRAM;
        timeout    = idle_run && !np && !ep && (idle_q == IDLE_LAST);

        unique case (state_q)
            ST_ENTRY: begin
                if (ep) begin
                    digit_d = '0;
                    if (idx_q == LAST_IDX) begin
                        idx_d      = '0;
                        mismatch_d = 1'b0;
                        if (!miss) begin
                            state_d = ST_UNLOCKED;
                            fail_d  = '0;
                        end else begin
                            fail_d = fail_q + 1'b1;
                            if (fail_q == FAIL_LAST) state_d = ST_LOCKOUT;
                        end
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        mismatch_d = miss;
                    end
                end else if (np) begin
                    digit_d = digit_q + 1'b1;
                end else if (timeout) begin
                    digit_d    = '0;
                    idx_d      = '0;
                    mismatch_d = 1'b0;
                end
            end
            ST_UNLOCKED: begin
                if (ep) begin
                    state_d = ST_ENTRY;
                end else if (np) begin
                    state_d = ST_PROGRAM;
                    digit_d = '0;
                    idx_d   = '0;
                end else if (timeout) begin
                    state_d = ST_ENTRY;
                end
            end
            ST_PROGRAM: begin
                if (ep) begin
                    shadow_d[int'(idx_q)*DIGIT_W +: DIGIT_W] = digit_q;
                    digit_d = '0;
                    if (idx_q == LAST_IDX) begin
                        code_d  = shadow_d;
                        idx_d   = '0;
                        state_d = ST_ENTRY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (np) begin
                    digit_d = digit_q + 1'b1;
                end else if (timeout) begin
                    state_d = ST_ENTRY;
                    digit_d = '0;
                    idx_d   = '0;
                end
            end
            ST_LOCKOUT: begin
                if (lock_q == LOCK_LAST) begin
                    state_d = ST_ENTRY;
                    fail_d  = '0;
                end else begin
                    lock_d = lock_q + 1'b1;
                end
            end
            default: state_d = ST_ENTRY;
        endcase

        // Idle count restarts on any press, on expiry and on every state change.
        if (idle_run && !np && !ep && !timeout && state_d == state_q)
            idle_d = idle_q + 1'b1;

        unique case (state_d)
            ST_UNLOCKED: led_d = LED_UNLOCKED[DIGIT_W-1:0];
            ST_LOCKOUT:  led_d = '0;
            default:     led_d = digit_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_ENTRY;
            digit_q       <= '0;
            idx_q         <= '0;
            mismatch_q    <= 1'b0;
            fail_q        <= '0;
            code_q        <= CODE;
            shadow_q      <= '0;
            idle_q        <= '0;
            lock_q        <= '0;
            led_q         <= '0;
            unlocked_q    <= 1'b0;
            lockout_q     <= 1'b0;
            programming_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            digit_q       <= digit_d;
            idx_q         <= idx_d;
            mismatch_q    <= mismatch_d;
            fail_q        <= fail_d;
            code_q        <= code_d;
            shadow_q      <= shadow_d;
            idle_q        <= idle_d;
            lock_q        <= lock_d;
            led_q         <= led_d;
            unlocked_q    <= (state_d == ST_UNLOCKED);
            lockout_q     <= (state_d == ST_LOCKOUT);
            programming_q <= (state_d == ST_PROGRAM);
        end
    end

    assign led         = led_q;
    assign unlocked    = unlocked_q;
    assign lockout     = lockout_q;
    assign programming = programming_q;
    assign fail_count  = fail_q;

endmodule

// File: tb/tb_code_lock.sv
// Bench for code_lock: directed scenarios plus randomized attempts against a rule-level model.
module tb_code_lock;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_next = 1'b0;
    logic       btn_enter = 1'b0;
    logic [3:0] led;
    logic       unlocked, lockout, programming;
    logic [1:0] fail_count;

    code_lock #(
        .DIGITS(4), .DIGIT_W(4), .CODE(16'h3141), .MAX_TRIES(3),
        .LOCKOUT_CYCLES(50), .TIMEOUT_CYCLES(100), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .btn_next(btn_next), .btn_enter(btn_enter),
        .led(led), .unlocked(unlocked), .lockout(lockout),
        .programming(programming), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: mode 0=entry 1=unlocked 2=program 3=lockout
    int m_mode, m_digit, m_fails;
    int m_code[4];
    int m_seq[$];

    logic lock_clr = 1'b0;
    int   lock_run = 0;
    always @(negedge clk) begin
        if (lock_clr) lock_run <= 0;
        else if (lockout === 1'b1) lock_run <= lock_run + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_led();
        if (m_mode == 1) return 15;
        if (m_mode == 3) return 0;
        return m_digit;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_led"}, 32'(led), exp_led());
        chk({tag, "_unlocked"}, 32'(unlocked), (m_mode == 1) ? 1 : 0);
        chk({tag, "_lockout"}, 32'(lockout), (m_mode == 3) ? 1 : 0);
        chk({tag, "_programming"}, 32'(programming), (m_mode == 2) ? 1 : 0);
        chk({tag, "_fail_count"}, 32'(fail_count), m_fails);
    endtask

    task automatic m_reset();
        m_mode = 0; m_digit = 0; m_fails = 0;
        m_code = '{1, 4, 1, 3};
        m_seq.delete();
    endtask

    task automatic m_next();
        if (m_mode == 0 || m_mode == 2) m_digit = (m_digit + 1) % 16;
        else if (m_mode == 1) begin
            m_mode = 2; m_digit = 0; m_seq.delete();
        end
    endtask

    task automatic m_enter();
        bit ok;
        if (m_mode == 1) begin
            m_mode = 0;
        end else if (m_mode == 0 || m_mode == 2) begin
            m_seq.push_back(m_digit);
            m_digit = 0;
            if (m_seq.size() == 4) begin
                if (m_mode == 2) begin
                    for (int k = 0; k < 4; k++) m_code[k] = m_seq[k];
                    m_mode = 0;
                end else begin
                    ok = 1'b1;
                    for (int k = 0; k < 4; k++) if (m_seq[k] != m_code[k]) ok = 1'b0;
                    if (ok) begin
                        m_mode = 1; m_fails = 0;
                    end else begin
                        m_fails++;
                        if (m_fails == 3) m_mode = 3;
                    end
                end
                m_seq.delete();
            end
        end
    endtask

    task automatic m_timeout();
        if (m_mode != 3) begin
            m_mode = 0; m_digit = 0; m_seq.delete();
        end
    endtask

    task automatic do_reset(input string tag);
        btn_next = 1'b0; btn_enter = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_reset();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic press(input bit enter, input int hold);
        if (enter) btn_enter = 1'b1; else btn_next = 1'b1;
        repeat (hold) @(negedge clk);
        btn_enter = 1'b0; btn_next = 1'b0;
        repeat (10) @(negedge clk);
        if (enter) m_enter(); else m_next();
    endtask

    task automatic dial(input int v, input string tag);
        for (int j = 0; j < v; j++) begin
            press(1'b0, $urandom_range(6, 10));
            check_all(tag);
        end
    endtask

    task automatic enter_code(input int d0, input int d1, input int d2, input int d3,
                              input string tag);
        int d[4];
        d = '{d0, d1, d2, d3};
        for (int k = 0; k < 4; k++) begin
            dial(d[k], tag);
            press(1'b1, 8);
            check_all(tag);
        end
    endtask

    initial begin
        int v;
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all("reset");

        enter_code(1, 4, 1, 3, "unlock");
        press(1'b1, 8);
        check_all("relock");

        enter_code(1, 4, 1, 2, "bad1");
        enter_code(1, 4, 1, 2, "bad2");
        lock_clr = 1'b1;
        @(negedge clk);
        lock_clr = 1'b0;
        enter_code(1, 4, 1, 2, "bad3");
        press(1'b0, 8);
        check_all("lock_ignore");
        for (int i = 0; i < 200 && lockout !== 1'b0; i++) @(negedge clk);
        @(negedge clk);
        m_mode = 0; m_fails = 0;
        chk("lock_len", 32'(lock_run), 50);
        check_all("lock_end");

        dial(17, "wrap");
        btn_next = 1'b1;
        repeat (3) @(negedge clk);
        btn_next = 1'b0;
        repeat (12) @(negedge clk);
        check_all("glitch");
        press(1'b0, 20);
        check_all("hold");
        btn_next = 1'b1; btn_enter = 1'b1;
        repeat (8) @(negedge clk);
        btn_next = 1'b0; btn_enter = 1'b0;
        repeat (10) @(negedge clk);
        m_enter();
        check_all("both");
        do_reset("reset2");

        enter_code(2, 0, 0, 0, "tofail");
        dial(1, "to_d");
        press(1'b1, 8);
        check_all("to_e");
        dial(1, "to_d");
        press(1'b0, 8);
        check_all("to_n");
        repeat (70) @(negedge clk);
        check_all("to_before");
        repeat (40) @(negedge clk);
        m_timeout();
        check_all("to_after");
        enter_code(1, 4, 1, 3, "to_unlock");

        press(1'b0, 8);
        check_all("prog_enter");
        enter_code(2, 2, 2, 2, "prog");
        enter_code(1, 4, 1, 3, "old_code");
        enter_code(2, 2, 2, 2, "new_code");
        press(1'b0, 8);
        check_all("prog2");
        dial(3, "prog2");
        press(1'b1, 8);
        check_all("prog2");
        do_reset("reset_prog");
        enter_code(1, 4, 1, 3, "code_reverted");

        do_reset("reset3");
        for (int it = 0; it < 10; it++) begin
            if (m_mode == 0) begin
                bit good;
                good = 1'(($urandom_range(0, 1)));
                for (int k = 0; k < 4; k++) begin
                    v = good ? m_code[k] : $urandom_range(0, 6);
                    dial(v, "rnd_dial");
                    press(1'b1, $urandom_range(6, 10));
                    check_all("rnd_enter");
                end
            end else if (m_mode == 1) begin
                if ($urandom_range(0, 1) == 0) begin
                    press(1'b1, 8);
                    check_all("rnd_relock");
                end else begin
                    press(1'b0, 8);
                    check_all("rnd_prog");
                    for (int k = 0; k < 4; k++) begin
                        dial($urandom_range(0, 6), "rnd_pdial");
                        press(1'b1, 8);
                        check_all("rnd_pent");
                    end
                end
            end else if (m_mode == 3) begin
                repeat (60) @(negedge clk);
                m_mode = 0; m_fails = 0;
                check_all("rnd_lockend");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
